// File: rtl/instr_prefetch_queue_if.sv
// ----------------------------------------------------------------------------
// instr_prefetch_queue_if
//
// Purpose: bundles the redirect, instruction-memory and decoder-facing signals
// of the instruction prefetch queue into one interface.
//
// Signal summary:
//   flush, flush_addr[31:0]      redirect pulse and new fetch address
//   mem_req, mem_addr[31:0]      read request to instruction memory
//   mem_ack, mem_rdata[31:0]     memory response for the current request
//   instr_valid, instr_data,
//   instr_pc, instr_ready        valid/ready hand-off of the FIFO head
//   fifo_count                   registered FIFO occupancy
//
// Modports:
//   master - the prefetch queue itself
//   slave  - the surrounding system (control path, memory, decoder)
// ----------------------------------------------------------------------------
interface instr_prefetch_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             flush;
    logic [31:0]      flush_addr;
    logic             mem_req;
    logic [31:0]      mem_addr;
    logic             mem_ack;
    logic [31:0]      mem_rdata;
    logic             instr_valid;
    logic [31:0]      instr_data;
    logic [31:0]      instr_pc;
    logic             instr_ready;
    logic [CNT_W-1:0] fifo_count;

    modport master (
        input  flush, flush_addr, mem_ack, mem_rdata, instr_ready,
        output mem_req, mem_addr, instr_valid, instr_data, instr_pc, fifo_count
    );

    modport slave (
        output flush, flush_addr, mem_ack, mem_rdata, instr_ready,
        input  mem_req, mem_addr, instr_valid, instr_data, instr_pc, fifo_count
    );
endinterface

// File: rtl/instr_prefetch_queue.sv
// ----------------------------------------------------------------------------
// instr_prefetch_queue
//
// Purpose: fetch stage in front of the instruction decoder. Owns the fetch PC,
// issues word reads to instruction memory over a req/ack handshake, buffers
// returned {word, address} pairs in a DEPTH-entry FIFO and presents the FIFO
// head to the decoder over valid/ready. A flush discards everything buffered
// and any in-flight word, and restarts fetching at the new address.
//
// Parameters:
//   DEPTH        FIFO entries (power of two, >= 2)
//   RESET_VECTOR first fetch address after reset
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    instr_prefetch_queue_if.master (flush, memory and decoder signals)
//
// Build option:
//   PREFETCH_BYPASS_EN  when defined, a word acked while the FIFO is empty is
//                       presented to the decoder in the same cycle and is not
//                       pushed if the decoder takes it. When undefined there is
//                       no combinational path from mem_* to instr_*.
// ----------------------------------------------------------------------------
module instr_prefetch_queue #(
    parameter int unsigned DEPTH        = 4,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    instr_prefetch_queue_if.master bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD
    } state_e;

    state_e           state_q, state_d;
    logic             mem_req_q, mem_req_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;

    logic [31:0]      data_mem [DEPTH];
    logic [31:0]      pc_mem   [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_after;

    logic             fifo_empty;
    logic             push;
    logic             pop_fifo;
    logic             clear;
    logic             bypass_take;
    logic             instr_valid;
    logic [31:0]      flush_pc;
    logic [31:0]      next_addr;

    // Fetch addresses are word aligned, so the low bits of a redirect target are dropped.
    assign flush_pc   = bus.flush_addr & 32'hFFFF_FFFC;
    assign next_addr  = mem_addr_q + 32'd4;
    assign fifo_empty = (count_q == '0);

    // ------------------------------------------------------------------------
    // Decoder-facing head: decoded from the FIFO, optionally bypassed.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
        instr_valid    = 1'b0;
        bus.instr_data = 32'h0;
        bus.instr_pc   = 32'h0;
        bypass_take    = 1'b0;
        if (!fifo_empty) begin
            instr_valid    = 1'b1;
            bus.instr_data = data_mem[rd_ptr_q];
            bus.instr_pc   = pc_mem[rd_ptr_q];
        end
`ifdef PREFETCH_BYPASS_EN
        // Only an ack for a live request (REQ) carries a word worth delivering.
        else if (state_q == REQ && bus.mem_ack && !bus.flush) begin
            instr_valid    = 1'b1;
            bus.instr_data = bus.mem_rdata;
            bus.instr_pc   = mem_addr_q;
            bypass_take    = bus.instr_ready;
        end
`endif
    end

    assign bus.instr_valid = instr_valid;
    // A flush wins over a same-cycle pop; the bypassed word never sits in the FIFO.
    assign pop_fifo = !fifo_empty && bus.instr_ready && !bus.flush;

    // ------------------------------------------------------------------------
    // Fetch FSM: next state, request outputs and FIFO push/clear.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        fetch_pc_d  = fetch_pc_q;
        push        = 1'b0;
        clear       = 1'b0;
        count_after = count_q;

        unique case (state_q)
            IDLE: begin
                if (bus.flush) begin
                    clear      = 1'b1;
                    fetch_pc_d = flush_pc;
                    state_d    = REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = flush_pc;
                end else if (count_q < FULL) begin
                    state_d    = REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc_q;
                end
            end

            REQ: begin
                if (bus.flush) begin
                    clear      = 1'b1;
                    fetch_pc_d = flush_pc;
                    if (bus.mem_ack) begin
                        // Request completed this edge; its word is dropped.
                        mem_addr_d = flush_pc;
                    end else begin
                        // The request cannot be withdrawn: wait out its ack.
                        state_d = DISCARD;
                    end
                end else if (bus.mem_ack) begin
                    push        = !bypass_take;
                    fetch_pc_d  = next_addr;
                    count_after = count_q + CNT_W'(push) - CNT_W'(pop_fifo);
                    // Keep one free slot for every outstanding request.
                    if (count_after < FULL) begin
                        mem_addr_d = next_addr;
                    end else begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                    end
                end
            end

            DISCARD: begin
                if (bus.flush) begin
                    clear      = 1'b1;
                    fetch_pc_d = flush_pc;
                end
                if (bus.mem_ack) begin
                    // Stale word dropped; reissue at the latest redirect target.
                    state_d    = REQ;
                    mem_addr_d = bus.flush ? flush_pc : fetch_pc_q;
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and control registers.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_VECTOR;
            fetch_pc_q <= RESET_VECTOR;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            fetch_pc_q <= fetch_pc_d;
            if (clear) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                if (pop_fifo) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop_fifo);
            end
        end
    end

    // NOTE: the storage array has no reset; occupancy lives in count_q and the head outputs are gated by it.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= bus.mem_rdata;
            pc_mem[wr_ptr_q]   <= mem_addr_q;
        end
    end

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.fifo_count = count_q;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// ----------------------------------------------------------------------------
// tb_instr_prefetch_queue
//
// Self-checking bench for instr_prefetch_queue (default build, DEPTH=4,
// RESET_VECTOR=0). Outputs are compared on the falling clock edge; inputs for
// the next rising edge are applied right after. The memory model returns
// mem_addr ^ KEY, so every delivered word can be tied back to its address.
// ----------------------------------------------------------------------------
module tb_instr_prefetch_queue;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] KEY   = 32'hC0DE_0000;

    typedef struct {
        logic        ack;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [2:0]  e_cnt;
    } vec_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    instr_prefetch_queue_if #(.DEPTH(DEPTH)) bus ();

    instr_prefetch_queue #(
        .DEPTH       (DEPTH),
        .RESET_VECTOR(32'h0000_0000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                              input logic valid, input logic [31:0] pc, input logic [2:0] cnt);
        logic [31:0] exp_data;
        exp_data = valid ? (pc ^ KEY) : 32'h0;
        check({tag, ".mem_req"},     {31'h0, bus.mem_req},     {31'h0, req});
        check({tag, ".mem_addr"},    bus.mem_addr,             addr);
        check({tag, ".instr_valid"}, {31'h0, bus.instr_valid}, {31'h0, valid});
        check({tag, ".instr_pc"},    bus.instr_pc,             valid ? pc : 32'h0);
        check({tag, ".instr_data"},  bus.instr_data,           exp_data);
        check({tag, ".fifo_count"},  {29'h0, bus.fifo_count},  {29'h0, cnt});
    endtask

    // Apply inputs for the coming rising edge, then advance to the next falling edge.
    task automatic drive(input logic fl, input logic [31:0] fa, input logic ack, input logic rdy);
        bus.flush       = fl;
        bus.flush_addr  = fa;
        bus.mem_ack     = ack;
        bus.mem_rdata   = ack ? (bus.mem_addr ^ KEY) : 32'h0;
        bus.instr_ready = rdy;
        @(negedge clk);
    endtask

    vec_t tbl [18];

    initial begin
        total = 0;
        bad   = 0;

        // Fill from empty with the decoder stalled, then stream with ready=1.
        //            ack  rdy  req  addr          valid pc            cnt
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 3'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 3'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000, 3'd1};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000, 3'd2};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_0000, 3'd3};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h0000_000C, 1'b1, 32'h0000_0000, 3'd4};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h0000_000C, 1'b1, 32'h0000_0000, 3'd4};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h0000_000C, 1'b1, 32'h0000_0004, 3'd3};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0004, 3'd3};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0004, 3'd3};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 32'h0000_0014, 1'b1, 32'h0000_0008, 3'd3};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 32'h0000_0018, 1'b1, 32'h0000_000C, 3'd3};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 32'h0000_001C, 1'b1, 32'h0000_0010, 3'd3};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 32'h0000_0020, 1'b1, 32'h0000_0014, 3'd3};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 32'h0000_0020, 1'b1, 32'h0000_0018, 3'd2};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 32'h0000_0020, 1'b1, 32'h0000_001C, 3'd1};
        tbl[16] = '{1'b1, 1'b1, 1'b1, 32'h0000_0020, 1'b0, 32'h0000_0000, 3'd0};
        tbl[17] = '{1'b0, 1'b0, 1'b1, 32'h0000_0024, 1'b1, 32'h0000_0020, 3'd1};

        reset           = 1'b0;
        bus.flush       = 1'b0;
        bus.flush_addr  = 32'h0;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = 32'h0;
        bus.instr_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 18; i++) begin
            expect_out($sformatf("v%0d", i), tbl[i].e_req, tbl[i].e_addr,
                       tbl[i].e_valid, tbl[i].e_pc, tbl[i].e_cnt);
            drive(1'b0, 32'h0, tbl[i].ack, tbl[i].ready);
        end

        // Asynchronous reset between edges while a request is pending at 0x24.
        #2 reset = 1'b0;
        #1 expect_out("async_rst", 1'b0, 32'h0000_0000, 1'b0, 32'h0, 3'd0);
        @(negedge clk);
        reset = 1'b1;
        expect_out("rst_rel", 1'b0, 32'h0000_0000, 1'b0, 32'h0, 3'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        expect_out("rst_first", 1'b1, 32'h0000_0000, 1'b0, 32'h0, 3'd0);

        // Flush to 0x100 while the request at 0x8 waits three cycles for its ack.
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        expect_out("fl_a", 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000, 3'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        expect_out("fl_b", 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004, 3'd1);
        drive(1'b1, 32'h0000_0100, 1'b0, 1'b1);
        expect_out("fl_disc1", 1'b1, 32'h0000_0008, 1'b0, 32'h0, 3'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        expect_out("fl_disc2", 1'b1, 32'h0000_0008, 1'b0, 32'h0, 3'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        expect_out("fl_disc3", 1'b1, 32'h0000_0008, 1'b0, 32'h0, 3'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        expect_out("fl_reissue", 1'b1, 32'h0000_0100, 1'b0, 32'h0, 3'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        expect_out("fl_first", 1'b1, 32'h0000_0104, 1'b1, 32'h0000_0100, 3'd1);

        // Flush to unaligned 0x203 coincident with an ack and a pop, FIFO holding 2.
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        expect_out("fc_full2", 1'b1, 32'h0000_0108, 1'b1, 32'h0000_0100, 3'd2);
        drive(1'b1, 32'h0000_0203, 1'b1, 1'b1);
        expect_out("fc_clear", 1'b1, 32'h0000_0200, 1'b0, 32'h0, 3'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        expect_out("fc_first", 1'b1, 32'h0000_0204, 1'b1, 32'h0000_0200, 3'd1);

        // Address wrap from 0xFFFF_FFFC to 0x0.
        drive(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
        expect_out("wr_top", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 3'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        expect_out("wr_wrap", 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 3'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        expect_out("wr_next", 1'b1, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC, 3'd2);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        expect_out("wr_pop", 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000, 3'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
